prog_counter_gen: RTL

Parametrised successor to the team's fixed 8-bit programmable counter.
- Generalised to WIDTH bits, with up/down direction, a programmable prescaler, a limit register, and three terminal-count modes (free-run, auto-reload, one-shot).
- Produces a registered terminal-count pulse and a one-shot done flag.
- Sits behind the tile's I/O wrapper as the core timing/counting engine.

---
 rtl/prog_counter_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/prog_counter_gen.sv
// prog_counter_gen: parameterised up/down counter with a prescaler, a limit
// register and three terminal-count modes (free-run, auto-reload, one-shot).
// It produces a registered one-cycle terminal-count pulse (tc) and a sticky
// one-shot expired flag (done).
// Optional feature macro: CNT_CAPTURE_EN. When it is defined, the count is
// snapshotted into cap_val on any edge where capture is high. When it is
// undefined, cap_val is tied to zero and capture is ignored.
//
// Control priority on each edge: rst (async) > load > prescaler tick step.
module prog_counter_gen #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  capture,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done,
  output logic [WIDTH-1:0]      cap_val
);

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_RELOAD = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic [1:0]            mode_eff;
  logic                  tick;
  logic                  term;

  // Terminal condition and prescaler tick for the current cycle
  always_comb begin
    // Mode 11 has no meaning of its own and behaves as free-run.
    mode_eff = (mode == 2'b11) ? MODE_FREE : mode;
    // The >= compare keeps the tick period bounded when prescale is lowered
    // below the current prescaler count mid-run.
    tick = (pre_cnt_q >= prescale);
    if (dir) begin
      term = (mode_eff == MODE_FREE) ? (count_q == '1) : (count_q == limit);
    end else begin
      term = (count_q == '0);
    end
  end

  // Next-state logic: load wins over the tick step; tc is a single-cycle pulse
  always_comb begin
    count_d   = count_q;
    pre_cnt_d = pre_cnt_q;
    tc_d      = 1'b0;
    done_d    = done_q;
    if (load) begin
      count_d   = load_val;
      pre_cnt_d = '0;
      done_d    = 1'b0;
    end else if (en) begin
      if (tick) begin
        pre_cnt_d = '0;
        // Once a one-shot has expired, ticks are ignored until load or rst.
        if (!done_q) begin
          if (!term) begin
            count_d = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
          end else begin
            tc_d = 1'b1;
            case (mode_eff)
              MODE_RELOAD:  count_d = dir ? '0 : limit;
              MODE_ONESHOT: done_d  = 1'b1;
              default:      count_d = dir ? '0 : '1;
            endcase
          end
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // Counter state registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      pre_cnt_q <= '0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
      done_q    <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

`ifdef CNT_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q, cap_val_d;

  // Capture snapshots the pre-update count, independent of en and load
  always_comb begin
    cap_val_d = cap_val_q;
    if (capture) cap_val_d = count_q;
  end

  // Capture register, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cap_val_q <= '0;
    else     cap_val_q <= cap_val_d;
  end

  assign cap_val = cap_val_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_val        = '0;
`endif

endmodule
